// File: rtl/umi_pkg.sv
// Shared UMI command constants, field offsets and atomic type codes.
package umi_pkg;

    localparam int OPC_LSB  = 0;
    localparam int SIZE_LSB = 5;
    localparam int LEN_LSB  = 8;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;

    localparam logic [7:0] UMI_ATOMIC_ADD  = 8'h00;
    localparam logic [7:0] UMI_ATOMIC_AND  = 8'h01;
    localparam logic [7:0] UMI_ATOMIC_OR   = 8'h02;
    localparam logic [7:0] UMI_ATOMIC_XOR  = 8'h03;
    localparam logic [7:0] UMI_ATOMIC_SWAP = 8'h08;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [4:0] opcode;
    } umi_cmd_t;

    function automatic logic [16:0] umi_bytes(
        input logic [2:0] size,
        input logic [7:0] len
    );
        logic [16:0] n;
        n = {9'd0, len} + 17'd1;
        return n << size;
    endfunction

endpackage

// File: rtl/umiram_atomic_alu.sv
// Read-modify-write datapath for UMI atomics (used with UMIRAM_ATOMIC_EN).
module umiram_atomic_alu
    import umi_pkg::*;
(
    input  logic [63:0] old_val,
    input  logic [63:0] operand,
    input  logic [7:0]  atype,
    output logic [63:0] new_val
);

    // Full 64-bit result; only the operand-sized low bytes are stored,
    // which gives wrap-around in the operand width for ADD.
    always_comb begin
        new_val = old_val;
        unique case (1'b1)
            atype == UMI_ATOMIC_ADD:  new_val = old_val + operand;
            atype == UMI_ATOMIC_AND:  new_val = old_val & operand;
            atype == UMI_ATOMIC_OR:   new_val = old_val | operand;
            atype == UMI_ATOMIC_XOR:  new_val = old_val ^ operand;
            atype == UMI_ATOMIC_SWAP: new_val = operand;
            default:                  new_val = old_val;
        endcase
    end

endmodule

// File: rtl/umiram_core.sv
// UMI device-side byte-addressed RAM with a single registered response.
// Define UMIRAM_ATOMIC_EN to add REQ_ATOMIC support.
module umiram_core
    import umi_pkg::*;
#(
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int RAMAW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << RAMAW;

    logic [7:0] mem [DEPTH];

    umi_cmd_t         req_f;
    logic [16:0]      nbytes;
    logic [16:0]      span;
    logic             fits;
    logic             accept;
    logic             is_atomic;
    logic [RAMAW-1:0] base;
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    wdata;
    logic             do_write;
    logic             do_resp;
    logic             rd_resp;
    logic [4:0]       resp_opc;
    logic [CW-1:0]    resp_cmd;

    assign req_f  = umi_cmd_t'(udev_req_cmd[15:0]);
    assign nbytes = umi_bytes(req_f.size, req_f.len);
    assign base   = udev_req_dstaddr[RAMAW-1:0];

    assign udev_req_ready = !rst && (!udev_resp_valid || udev_resp_ready);
    assign accept         = udev_req_valid && udev_req_ready;

`ifdef UMIRAM_ATOMIC_EN
    logic [63:0] amo_new;

    assign is_atomic = (req_f.opcode == UMI_REQ_ATOMIC) &&
                       (req_f.size <= 3'd3);

    umiram_atomic_alu u_alu (
        .old_val (rd_data[63:0]),
        .operand (udev_req_data[63:0]),
        .atype   (req_f.len),
        .new_val (amo_new)
    );

    assign wdata = is_atomic ? DW'(amo_new) : udev_req_data;
`else
    assign is_atomic = 1'b0;
    assign wdata     = udev_req_data;
`endif

    // Atomics carry atype in the len field, so their span is 1<<size.
    assign span = is_atomic ? (17'd1 << req_f.size) : nbytes;
    assign fits = span <= 17'(NB);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (17'(i) < span) begin
                rd_data[8*i +: 8] = mem[base + RAMAW'(i)];
            end
        end
    end

    always_comb begin
        do_write = 1'b0;
        do_resp  = 1'b0;
        rd_resp  = 1'b0;
        resp_opc = UMI_RESP_WRITE;
        if (fits) begin
            unique case (1'b1)
                req_f.opcode == UMI_REQ_READ: begin
                    do_resp  = 1'b1;
                    rd_resp  = 1'b1;
                    resp_opc = UMI_RESP_READ;
                end
                req_f.opcode == UMI_REQ_WRITE: begin
                    do_write = 1'b1;
                    do_resp  = 1'b1;
                end
                req_f.opcode == UMI_REQ_POSTED: begin
                    do_write = 1'b1;
                end
                is_atomic: begin
                    do_write = 1'b1;
                    do_resp  = 1'b1;
                    rd_resp  = 1'b1;
                    resp_opc = UMI_RESP_READ;
                end
                default: begin
                    do_write = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        resp_cmd = udev_req_cmd;
        resp_cmd[OPC_LSB +: 5] = resp_opc;
        if (is_atomic) begin
            resp_cmd[LEN_LSB +: 8] = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (17'(i) < span) begin
                    mem[base + RAMAW'(i)] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            udev_resp_valid   <= 1'b0;
            udev_resp_cmd     <= '0;
            udev_resp_dstaddr <= '0;
            udev_resp_srcaddr <= '0;
            udev_resp_data    <= '0;
        end else if (accept) begin
            udev_resp_valid <= do_resp;
            if (do_resp) begin
                udev_resp_cmd     <= resp_cmd;
                udev_resp_dstaddr <= udev_req_srcaddr;
                udev_resp_srcaddr <= udev_req_dstaddr;
                udev_resp_data    <= rd_resp ? rd_data : '0;
            end
        end else if (udev_resp_ready) begin
            udev_resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_umiram_core.sv
// Randomized bench for umiram_core against a byte-array reference model.
// Atomic scenarios are compiled in when UMIRAM_ATOMIC_EN is defined.
`timescale 1ns/1ps
module tb_umiram_core;

    localparam int NB  = 32;
    localparam int MSZ = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         udev_req_valid;
    logic [31:0]  udev_req_cmd;
    logic [63:0]  udev_req_dstaddr;
    logic [63:0]  udev_req_srcaddr;
    logic [255:0] udev_req_data;
    logic         udev_req_ready;
    logic         udev_resp_valid;
    logic [31:0]  udev_resp_cmd;
    logic [63:0]  udev_resp_dstaddr;
    logic [63:0]  udev_resp_srcaddr;
    logic [255:0] udev_resp_data;
    logic         udev_resp_ready;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int nresp  = 0;
    bit rr_rand = 1'b0;

    typedef struct {
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
    } resp_t;

    resp_t      expq[$];
    resp_t      prev;
    logic       hold_q = 1'b0;
    logic [7:0] ref_mem [MSZ];

    umiram_core #(
        .DW(256), .AW(64), .CW(32), .RAMAW(12)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .udev_req_valid    (udev_req_valid),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_req_ready    (udev_req_ready),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_srcaddr (udev_resp_srcaddr),
        .udev_resp_data    (udev_resp_data),
        .udev_resp_ready   (udev_resp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-array model applied at each accepted request.
    task automatic model_accept(input logic [31:0] cmd,
                                input logic [63:0] dst,
                                input logic [63:0] src,
                                input logic [255:0] wd);
        int opc, sz, ln, nb, a;
        bit amo, resp, wr;
        resp_t r;
        logic [63:0] oldv, newv;
        opc = int'(cmd[4:0]);
        sz  = int'(cmd[7:5]);
        ln  = int'(cmd[15:8]);
        a   = int'(dst[11:0]);
        amo = 1'b0;
`ifdef UMIRAM_ATOMIC_EN
        amo = (opc == 9) && (sz <= 3);
`endif
        nb = amo ? (1 << sz) : ((ln + 1) << sz);
        if (nb > NB) return;
        r.cmd = cmd; r.dst = src; r.src = dst; r.data = '0;
        resp = 1'b0; wr = 1'b0;
        if (opc == 1) begin
            resp = 1'b1;
            r.cmd[4:0] = 5'h02;
            for (int i = 0; i < nb; i++)
                r.data[8*i +: 8] = ref_mem[(a + i) % MSZ];
        end else if (opc == 3) begin
            resp = 1'b1; wr = 1'b1;
            r.cmd[4:0] = 5'h04;
        end else if (opc == 5) begin
            wr = 1'b1;
        end else if (amo) begin
            oldv = '0;
            for (int i = 0; i < nb; i++)
                oldv[8*i +: 8] = ref_mem[(a + i) % MSZ];
            case (ln)
                0:       newv = oldv + wd[63:0];
                1:       newv = oldv & wd[63:0];
                2:       newv = oldv | wd[63:0];
                3:       newv = oldv ^ wd[63:0];
                8:       newv = wd[63:0];
                default: newv = oldv;
            endcase
            r.data = {192'd0, oldv};
            r.cmd[4:0] = 5'h02;
            r.cmd[15:8] = 8'd0;
            resp = 1'b1;
            for (int i = 0; i < nb; i++)
                ref_mem[(a + i) % MSZ] = newv[8*i +: 8];
        end
        if (wr)
            for (int i = 0; i < nb; i++)
                ref_mem[(a + i) % MSZ] = wd[8*i +: 8];
        if (resp) expq.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            hold_q <= 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", 256'(udev_resp_valid), 256'(1));
                check("hold_cmd", udev_resp_cmd, prev.cmd);
                check("hold_dst", udev_resp_dstaddr, prev.dst);
                check("hold_src", udev_resp_srcaddr, prev.src);
                check("hold_data", udev_resp_data, prev.data);
            end
            if (udev_resp_valid && udev_resp_ready) begin
                check("resp_expected", 256'(expq.size() != 0), 256'(1));
                if (expq.size() != 0) begin
                    resp_t e;
                    e = expq.pop_front();
                    check("resp_cmd", udev_resp_cmd, e.cmd);
                    check("resp_dst", udev_resp_dstaddr, e.dst);
                    check("resp_src", udev_resp_srcaddr, e.src);
                    check("resp_data", udev_resp_data, e.data);
                end
                nresp++;
            end
            hold_q <= udev_resp_valid && !udev_resp_ready;
            prev <= '{udev_resp_cmd, udev_resp_dstaddr,
                      udev_resp_srcaddr, udev_resp_data};
            if (udev_req_valid && udev_req_ready)
                model_accept(udev_req_cmd, udev_req_dstaddr,
                             udev_req_srcaddr, udev_req_data);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [31:0] c, input logic [63:0] d,
                        input logic [63:0] s, input logic [255:0] w);
        bit acc;
        acc = 1'b0;
        udev_req_valid   = 1'b1;
        udev_req_cmd     = c;
        udev_req_dstaddr = d;
        udev_req_srcaddr = s;
        udev_req_data    = w;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = udev_req_ready;
            @(posedge clk); #1;
            if (rr_rand) udev_resp_ready = ($urandom_range(0, 3) != 0);
        end
        check("accepted", 256'(acc), 256'(1));
    endtask

    task automatic idle();
        udev_req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    logic [255:0] pd;
    int t0, n0;
    int atypes [5] = '{0, 1, 2, 3, 8};

    initial begin
        udev_req_valid   = 1'b0;
        udev_req_cmd     = '0;
        udev_req_dstaddr = '0;
        udev_req_srcaddr = '0;
        udev_req_data    = '0;
        udev_resp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 256'(udev_req_ready), 256'(0));
        check("rst_resp_valid", 256'(udev_resp_valid), 256'(0));
        check("rst_resp_cmd", udev_resp_cmd, 0);
        check("rst_resp_dst", udev_resp_dstaddr, 0);
        check("rst_resp_src", udev_resp_srcaddr, 0);
        check("rst_resp_data", udev_resp_data, 0);
        step();
        rst = 1'b0;

        send(32'h43, 64'h10, 64'h1000, 256'hDEADBEEF);
        idle();
        @(negedge clk);
        check("wr_valid", 256'(udev_resp_valid), 256'(1));
        check("wr_cmd", udev_resp_cmd, 32'h44);
        check("wr_dst", udev_resp_dstaddr, 64'h1000);
        check("wr_src", udev_resp_srcaddr, 64'h10);
        check("wr_data", udev_resp_data, 0);
        step();

        send(32'h41, 64'h10, 64'h2000, '0);
        idle();
        @(negedge clk);
        check("rd_cmd", udev_resp_cmd, 32'h42);
        check("rd_data", udev_resp_data, 256'hDEADBEEF);
        step();

        pd = rnd256();
        send(32'h1F05, 64'h100, 64'h3000, pd);
        idle();
        @(negedge clk);
        check("posted_no_resp", 256'(udev_resp_valid), 256'(0));
        step();
        send(32'h1F01, 64'h100, 64'h3000, '0);
        idle();
        @(negedge clk);
        check("posted_readback", udev_resp_data, pd);
        step();

        send(32'h2005, 64'h100, 64'h3000, rnd256());
        idle();
        @(negedge clk);
        check("oversize_no_resp", 256'(udev_resp_valid), 256'(0));
        step();
        send(32'h1F01, 64'h100, 64'h3000, '0);
        idle();
        @(negedge clk);
        check("oversize_no_write", udev_resp_data, pd);
        step();

        send(32'h07, 64'h100, 64'h3000, rnd256());
        idle();
        @(negedge clk);
        check("unknown_no_resp", 256'(udev_resp_valid), 256'(0));
        step();

`ifdef UMIRAM_ATOMIC_EN
        send(32'h63, 64'h40, 64'h0, 256'h10);
        send(32'h69, 64'h40, 64'h0, 256'h5);
        idle();
        @(negedge clk);
        check("amo_cmd", udev_resp_cmd, 32'h62);
        check("amo_old", udev_resp_data, 256'h10);
        step();
        send(32'h61, 64'h40, 64'h0, '0);
        idle();
        @(negedge clk);
        check("amo_new", udev_resp_data, 256'h15);
        step();
`else
        send(32'h69, 64'h40, 64'h0, 256'h5);
        idle();
        @(negedge clk);
        check("amo_off_no_resp", 256'(udev_resp_valid), 256'(0));
        step();
`endif

        send(32'h63, 64'hABCD_0000_0000_0FFC, 64'h0,
             256'h0123456789ABCDEF);
        send(32'h61, 64'h0FFC, 64'h0, '0);
        idle();
        @(negedge clk);
        check("wrap_rd8", udev_resp_data, 256'h0123456789ABCDEF);
        step();
        send(32'h41, 64'h0, 64'h0, '0);
        idle();
        @(negedge clk);
        check("wrap_rd_low", udev_resp_data, 256'h01234567);
        step();

        send(32'h41, 64'h10, 64'h4000, '0);
        idle();
        udev_resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_req_ready", 256'(udev_req_ready), 256'(0));
            check("stall_data", udev_resp_data, 256'hDEADBEEF);
            step();
        end
        udev_resp_ready = 1'b1;
        t0 = cycle;
        n0 = nresp;
        for (int k = 0; k < 8; k++)
            send(32'h41, 64'h100 + 64'(4 * k), 64'h5000, '0);
        check("b2b_cycles", 256'(cycle - t0), 256'(8));
        idle();
        repeat (3) step();
        check("b2b_resps", 256'(nresp - n0), 256'(9));

        udev_resp_ready = 1'b0;
        send(32'h41, 64'h10, 64'h6000, '0);
        idle();
        @(negedge clk);
        check("pre_rst_valid", 256'(udev_resp_valid), 256'(1));
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_blocks_ready", 256'(udev_req_ready), 256'(0));
        step();
        check("post_rst_valid", 256'(udev_resp_valid), 256'(0));
        rst = 1'b0;
        udev_resp_ready = 1'b1;
        send(32'h41, 64'h10, 64'h7000, '0);
        idle();
        @(negedge clk);
        check("post_rst_read", udev_resp_data, 256'hDEADBEEF);
        step();

        for (int k = 0; k < 34; k++)
            send(32'h1F05, 64'(32 * k), 64'h0, rnd256());
        rr_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int op, sz, ln, mx, opc, a;
            logic [31:0] c;
            op  = $urandom_range(0, 9);
            sz  = $urandom_range(0, 5);
            mx  = (32 >> sz) - 1;
            ln  = $urandom_range(0, mx);
            opc = (op <= 3) ? 1 : (op <= 6) ? 3 : 5;
            if (op == 8) begin
                opc = 9;
                sz  = $urandom_range(0, 3);
                ln  = atypes[$urandom_range(0, 4)];
            end else if (op == 9) begin
                ln = mx + 1 + $urandom_range(0, 3);
            end
            a = $urandom_range(0, 'h3FF);
            c = $urandom;
            c[4:0]  = 5'(opc);
            c[7:5]  = 3'(sz);
            c[15:8] = 8'(ln);
            send(c, {$urandom, 20'd0, 12'(a)},
                 {$urandom, $urandom}, rnd256());
            if ($urandom_range(0, 3) == 0) begin
                idle();
                step();
            end
        end
        rr_rand = 1'b0;
        idle();
        udev_resp_ready = 1'b1;
        repeat (5) step();
        check("queue_drained", 256'(expq.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/umiram_core.md
UMIRAM_CORE -- requirements
Module: umiram

Interface
REQ-001 Parameter DW, default 256, UMI data width in bits (multiple of 64).
REQ-002 Parameter AW, default 64, UMI address width in bits.
REQ-003 Parameter CW, default 32, UMI command width in bits.
REQ-004 Parameter RAMAW, default 12, log2 of memory size in bytes.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 udev_req_valid  input  1  request valid.
REQ-008 udev_req_cmd  input  CW  UMI command.
REQ-009 udev_req_dstaddr  input  AW  target byte address.
REQ-010 udev_req_srcaddr  input  AW  requester return address.
REQ-011 udev_req_data  input  DW  write data, byte 0 in bits [7:0].
REQ-012 udev_req_ready  output  1  request accepted when high with valid.
REQ-013 udev_resp_valid  output  1  response valid.
REQ-014 udev_resp_cmd  output  CW  response command.
REQ-015 udev_resp_dstaddr  output  AW  equals request srcaddr.
REQ-016 udev_resp_srcaddr  output  AW  equals request dstaddr.
REQ-017 udev_resp_data  output  DW  read data; zero for write responses.
REQ-018 udev_resp_ready  input  1  response consumed when high with valid.

Function
REQ-019 Command fields: opcode cmd[4:0], size cmd[7:5], len cmd[15:8]; bytes = (len+1)<<size; all other bits are copied request to response.
REQ-020 Memory is a byte array of 2^RAMAW bytes indexed by dstaddr[RAMAW-1:0]; higher address bits are ignored; byte addresses wrap modulo 2^RAMAW.
REQ-021 Requests whose byte count exceeds DW/8 are accepted and dropped, with no memory change and no response.
REQ-022 udev_req_ready = !udev_resp_valid || udev_resp_ready, combinationally.
REQ-023 REQ_READ (0x01): the response appears the cycle after acceptance, with opcode RESP_READ (0x02), the same size/len, and data bytes [bytes-1:0] from memory; upper data bytes are zero.
REQ-024 REQ_WRITE (0x03): the memory is updated on the accept edge; the response the cycle after has opcode RESP_WRITE (0x04), the same size/len, and zero data.
REQ-025 REQ_POSTED (0x05): write as REQ_WRITE, with no response; udev_resp_valid falls if the previous response was consumed that cycle.
REQ-026 Other opcodes: accepted and discarded, with no response.
REQ-027 The response register holds all fields stable while valid and not ready.
REQ-028 A read on the cycle after a write to the same address returns the new data.
REQ-029 Accept and response consumption occur in the same cycle, giving full throughput of one request per cycle.

Reset
REQ-030 On rst, udev_resp_valid=0 and the other response outputs are 0; memory contents are not reset (undefined until written).
REQ-031 While rst is high, udev_req_ready=0; a pending response is discarded.

Configuration
REQ-032 With UMIRAM_ATOMIC_EN defined, REQ_ATOMIC (0x09) is supported, with atype cmd[15:8] (0x00 ADD, 0x01 AND, 0x02 OR, 0x03 XOR, 0x08 SWAP) on a (1<<size)-byte little-endian operand, size ≤ 3.
REQ-033 The atomic response is RESP_READ with len=0 and the old memory value; the memory is updated in the accept cycle.
REQ-034 Without UMIRAM_ATOMIC_EN, REQ_ATOMIC is handled per REQ-026.

Structure
REQ-035 Opcode constants, command field offsets and atomic type codes reside in shared package umi_pkg.
REQ-036 One sub-module, umiram_atomic_alu (combinational old/operand/atype -> new value), is instantiated only under UMIRAM_ATOMIC_EN.

Verification
REQ-037 Write of 0xDEADBEEF with size=2, len=0 to 0x10, srcaddr 0x1000 -> RESP_WRITE; resp dstaddr 0x1000, srcaddr 0x10.
REQ-038 Read with size=2, len=0 at 0x10 -> RESP_READ with data 0xDEADBEEF, upper bits zero.
REQ-039 Posted write of 32 bytes (size=0, len=31), then a read-back of the same -> identical data; no response for the posted write.
REQ-040 Hold udev_resp_ready low for 5 cycles with a read pending -> udev_req_ready low and the response held stable; on release, back-to-back requests produce one response per cycle.
REQ-041 Atomic ADD of 5 on 8-byte 0x10 at 0x40 (UMIRAM_ATOMIC_EN) -> response data 0x10; a subsequent read returns 0x15.
REQ-042 Assert rst while resp_valid=1 -> resp_valid is 0 the next cycle; data written before reset remains readable.
